// File: rtl/bayt_veri_bellegi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rv32i_bellek_pkg
//  Purpose  : Shared definitions for the byte-addressable data memory:
//             RV32I funct3 size codes, FSM state encoding and the size-code
//             legality check.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package rv32i_bellek_pkg;

   // RV32I funct3 load/store size codes
   localparam logic [2:0] c_boyut_b  = 3'b000;
   localparam logic [2:0] c_boyut_h  = 3'b001;
   localparam logic [2:0] c_boyut_w  = 3'b010;
   localparam logic [2:0] c_boyut_bu = 3'b100;
   localparam logic [2:0] c_boyut_hu = 3'b101;

   // Request FSM states
   typedef enum logic [1:0] {
      BOSTA  = 2'b00,
      MESGUL = 2'b01,
      YANIT  = 2'b10
   } durum_t;

   // Codes 011/110/111 never exist; unsigned variants only make sense for loads.
   function automatic logic boyut_gecersiz(input logic yaz, input logic [2:0] boyut);
      return (boyut == 3'b011) || (boyut == 3'b110) || (boyut == 3'b111) ||
             (yaz && boyut[2]);
   endfunction

endpackage
`default_nettype wire

// File: rtl/bayt_veri_bellegi_yukleme_hizalayici.sv
`default_nettype none
// ============================================================================
//  Module   : yukleme_hizalayici
//  Purpose  : Combinational load aligner. Selects the byte / halfword lane
//             of a memory word and sign- or zero-extends it to 32 bits.
//  Ports    : i_kelime [31:0] - raw memory word
//             i_boyut  [2:0]  - RV32I funct3 size code
//             i_bayt   [1:0]  - byte lane (address bits [1:0])
//             o_veri   [31:0] - aligned, extended result (0 for illegal codes)
//  Revision : 1.0 - initial release
// ============================================================================
module yukleme_hizalayici
   import rv32i_bellek_pkg::*;
(
   input  logic [31:0] i_kelime,
   input  logic [2:0]  i_boyut,
   input  logic [1:0]  i_bayt,
   output logic [31:0] o_veri
);

   logic [7:0]  w_bayt;
   logic [15:0] w_yarim;

   always_comb begin
      w_bayt  = i_kelime[{i_bayt, 3'b000} +: 8];
      // Halfword lane is chosen by address bit 1 only; bit 0 is ignored here.
      w_yarim = i_bayt[1] ? i_kelime[31:16] : i_kelime[15:0];
      o_veri  = 32'h0;
      case (i_boyut)
         c_boyut_b  : o_veri = {{24{w_bayt[7]}}, w_bayt};
         c_boyut_bu : o_veri = {24'h0, w_bayt};
         c_boyut_h  : o_veri = {{16{w_yarim[15]}}, w_yarim};
         c_boyut_hu : o_veri = {16'h0, w_yarim};
         c_boyut_w  : o_veri = i_kelime;
         default    : o_veri = 32'h0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/bayt_veri_bellegi.sv
`default_nettype none
// ============================================================================
//  Module   : bayt_veri_bellegi
//  Purpose  : Byte-addressable RV32I data memory with a valid/ready request
//             channel, a fixed response latency of BEKLEME cycles and a
//             valid/ready response channel. One request outstanding at a time.
//  Params   : DERINLIK - number of 32-bit words (power of two, 16..4096)
//             BEKLEME  - response latency in cycles (1..4)
//  Macro    : BAYT_VERI_BELLEGI_HIZA_DENETIM_EN - when defined, misaligned
//             halfword/word accesses and out-of-range addresses fault.
//             When undefined, address bits above the index wrap around.
//  Ports    : clk           - clock, rising edge
//             rst           - asynchronous reset, active low
//             istek_gecerli - request valid      istek_hazir - request ready
//             yaz_aktif     - 1 store / 0 load   boyut       - funct3 size
//             adres         - byte address       yaz_veri    - store data
//             yanit_gecerli - response valid     yanit_hazir - response ready
//             oku_veri      - load result        hata        - request fault
//  Revision : 1.0 - initial release
// ============================================================================
module bayt_veri_bellegi
   import rv32i_bellek_pkg::*;
#(
   parameter int DERINLIK = 256,
   parameter int BEKLEME  = 1
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        istek_gecerli,
   output logic        istek_hazir,
   input  logic        yaz_aktif,
   input  logic [2:0]  boyut,
   input  logic [31:0] adres,
   input  logic [31:0] yaz_veri,
   output logic        yanit_gecerli,
   input  logic        yanit_hazir,
   output logic [31:0] oku_veri,
   output logic        hata
);

   localparam int          c_indeks_w  = $clog2(DERINLIK);
   localparam logic [1:0]  c_sayac_yuk = 2'((BEKLEME > 1) ? (BEKLEME - 2) : 0);

   // Storage: not touched by reset, zero at time 0.
   logic [31:0] r_bellek [DERINLIK] = '{default: 32'h0};

   durum_t                r_durum;
   logic [1:0]            r_sayac;
   logic                  r_istek_hazir;
   logic                  r_yanit_gecerli;
   logic [31:0]           r_oku_veri;
   logic                  r_hata;

   logic                  w_kabul;
   logic [c_indeks_w-1:0] w_indeks;
   logic [1:0]            w_bayt;
   logic                  w_hiza_hata;
   logic                  w_hata;
   logic [3:0]            w_seritler;
   logic [31:0]           w_yaz_kelime;
   logic [31:0]           w_okunan;
   logic [31:0]           w_hizali;
   logic [31:0]           w_yanit_veri;

   assign w_kabul  = istek_gecerli && r_istek_hazir;
   assign w_indeks = adres[c_indeks_w+1:2];
   assign w_bayt   = adres[1:0];

`ifdef BAYT_VERI_BELLEGI_HIZA_DENETIM_EN
   // boyut[1:0]==01 covers H and HU, 10 is W; illegal codes fault elsewhere.
   assign w_hiza_hata = ((boyut[1:0] == 2'b01) && adres[0])          ||
                        ((boyut[1:0] == 2'b10) && (adres[1:0] != 2'b00)) ||
                        (|adres[31:c_indeks_w+2]);
`else
   // Upper address bits are deliberately ignored: the array wraps around.
   logic w_unused_ust_adres;
   assign w_unused_ust_adres = ^adres[31:c_indeks_w+2];
   assign w_hiza_hata        = 1'b0;
`endif

   assign w_hata = boyut_gecersiz(yaz_aktif, boyut) || w_hiza_hata;

   // Store lane enables and the store data replicated onto every lane.
   always_comb begin
      w_seritler   = 4'b0000;
      w_yaz_kelime = yaz_veri;
      case (boyut[1:0])
         2'b00: begin
            w_seritler   = 4'b0001 << w_bayt;
            w_yaz_kelime = {4{yaz_veri[7:0]}};
         end
         2'b01: begin
            w_seritler   = adres[1] ? 4'b1100 : 4'b0011;
            w_yaz_kelime = {2{yaz_veri[15:0]}};
         end
         2'b10:   w_seritler = 4'b1111;
         default: w_seritler = 4'b0000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_kabul && yaz_aktif && !w_hata) begin
         for (int i = 0; i < 4; i++) begin
            if (w_seritler[i]) begin
               r_bellek[w_indeks][8*i +: 8] <= w_yaz_kelime[8*i +: 8];
            end
         end
      end
   end

   assign w_okunan = r_bellek[w_indeks];

   yukleme_hizalayici u_hizalayici (
      .i_kelime (w_okunan),
      .i_boyut  (boyut),
      .i_bayt   (w_bayt),
      .o_veri   (w_hizali)
   );

   assign w_yanit_veri = (w_hata || yaz_aktif) ? 32'h0 : w_hizali;

   // Response data is captured at acceptance and held until handed off.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_durum         <= BOSTA;
         r_sayac         <= 2'd0;
         r_istek_hazir   <= 1'b0;
         r_yanit_gecerli <= 1'b0;
         r_oku_veri      <= 32'h0;
         r_hata          <= 1'b0;
      end else begin
         case (r_durum)
            BOSTA: begin
               if (w_kabul) begin
                  r_istek_hazir <= 1'b0;
                  r_oku_veri    <= w_yanit_veri;
                  r_hata        <= w_hata;
                  if (BEKLEME == 1) begin
                     r_durum         <= YANIT;
                     r_yanit_gecerli <= 1'b1;
                  end else begin
                     r_durum <= MESGUL;
                     r_sayac <= c_sayac_yuk;
                  end
               end else begin
                  r_istek_hazir <= 1'b1;
               end
            end
            MESGUL: begin
               if (r_sayac == 2'd0) begin
                  r_durum         <= YANIT;
                  r_yanit_gecerli <= 1'b1;
               end else begin
                  r_sayac <= r_sayac - 2'd1;
               end
            end
            YANIT: begin
               if (yanit_hazir) begin
                  r_durum         <= BOSTA;
                  r_yanit_gecerli <= 1'b0;
                  r_istek_hazir   <= 1'b1;
               end
            end
            default: begin
               r_durum         <= BOSTA;
               r_yanit_gecerli <= 1'b0;
               r_istek_hazir   <= 1'b0;
            end
         endcase
      end
   end

   assign istek_hazir   = r_istek_hazir;
   assign yanit_gecerli = r_yanit_gecerli;
   assign oku_veri      = r_oku_veri;
   assign hata          = r_hata;

endmodule
`default_nettype wire
